// File: rtl/chunked_addsub.sv
// chunked_addsub: multi-cycle add/subtract that processes CHUNK bits per clock,
// linking chunks through a registered carry, with valid/ready on both sides.
module chunked_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = N > 1 ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, nxt;
    logic [WIDTH-1:0] a_r, b_r;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [CHUNK-1:0] a_c, b_c;
    logic [CHUNK:0]   s;
    logic             last;

    assign a_c       = a_r[idx*CHUNK +: CHUNK];
    assign b_c       = b_r[idx*CHUNK +: CHUNK];
    assign s         = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry};
    assign last      = idx == IW'(N - 1);
    assign in_ready  = rst_n && state == IDLE;
    assign out_valid = state == DONE;

    always_comb begin
        nxt = (state == IDLE && in_valid)  ? RUN  :
              (state == RUN  && last)      ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && in_valid) begin
                a_r   <= a;
                b_r   <= sub ? ~b : b;
                carry <= sub ? ~cin : cin;
                idx   <= '0;
            end
            if (state == RUN) begin
                sum[idx*CHUNK +: CHUNK] <= s[CHUNK-1:0];
                carry <= s[CHUNK];
                idx   <= idx + 1'b1;
                // carry into the MSB is recovered from the MSB sum bit and its operands
                if (last) begin
                    co  <= s[CHUNK];
                    ovf <= s[CHUNK] ^ (a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ s[CHUNK-1]);
                end
            end
        end
    end
endmodule

// File: tb/tb_chunked_addsub.sv
// tb_chunked_addsub: drives CHUNK=4, 16 and 1 instances with directed and random
// operations and compares them against a plain-integer arithmetic model.
module tb_chunked_addsub;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a, b;
    logic        cin, sub;
    logic        in_valid  [3];
    logic        out_ready [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic [15:0] r_sum     [3];
    logic        r_co      [3];
    logic        r_ovf     [3];
    int          nlat      [3] = '{4, 1, 16};
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        chunked_addsub #(.WIDTH(16), .CHUNK(g == 0 ? 4 : g == 1 ? 16 : 1)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[g]),
            .out_ready(out_ready[g]), .sum(r_sum[g]), .co(r_co[g]), .ovf(r_ovf[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // {ovf, co, sum} from unbounded integer arithmetic
    function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv,
                                          input logic ci, input logic sb);
        int ua, ub, sa, sbv, r, sr;
        logic c, v;
        ua = int'(av);
        ub = int'(bv);
        sa = int'($signed(av));
        sbv = int'($signed(bv));
        if (sb) begin
            r  = ua - ub - int'(ci);
            c  = ua >= ub + int'(ci);
            sr = sa - sbv - int'(ci);
        end else begin
            r  = ua + ub + int'(ci);
            c  = r > 65535;
            sr = sa + sbv + int'(ci);
        end
        v = sr > 32767 || sr < -32768;
        return {v, c, r[15:0]};
    endfunction

    task automatic accept(input int d, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic sb);
        check("in_ready_before", 32'(in_ready[d]), 1);
        a = av; b = bv; cin = ci; sub = sb; in_valid[d] = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid[d] = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    endtask

    task automatic wait_out(input int d, input string tag);
        int lat = 0;
        while (!out_valid[d] && lat < 64) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        check(tag, lat, nlat[d]);
    endtask

    task automatic run(input int d, input logic [15:0] av, input logic [15:0] bv,
                       input logic ci, input logic sb, output logic [17:0] res);
        logic [17:0] e;
        e = model(av, bv, ci, sb);
        accept(d, av, bv, ci, sb);
        wait_out(d, "latency");
        res = {r_ovf[d], r_co[d], r_sum[d]};
        check("model", 32'(res), 32'(e));
        out_ready[d] = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready[d] = 1'b0;
        check("out_valid_drop", 32'(out_valid[d]), 0);
        check("in_ready_after", 32'(in_ready[d]), 1);
    endtask

    initial begin
        logic [17:0] res;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0;
            out_ready[i] = 1'b0;
        end
        a = '0; b = '0; cin = 1'b0; sub = 1'b0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready[0]), 0);
        check("rst_out_valid", 32'(out_valid[0]), 0);
        check("rst_result", {r_ovf[0], r_co[0], r_sum[0]}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 32'(in_ready[0]), 1);

        run(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, res);
        check("add_wrap", 32'(res), {2'b01, 16'h0000});
        run(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, res);
        check("add_ovf", 32'(res), {2'b10, 16'h8000});
        run(0, 16'h0005, 16'h0007, 1'b0, 1'b1, res);
        check("sub_neg", 32'(res), {2'b00, 16'hFFFE});
        run(0, 16'h8000, 16'h0001, 1'b0, 1'b1, res);
        check("sub_ovf", 32'(res), {2'b11, 16'h7FFF});
        run(0, 16'h0010, 16'h0001, 1'b1, 1'b1, res);
        check("sub_borrow_in", 32'(res[16:0]), {1'b1, 16'h000E});

        accept(0, 16'h1234, 16'h0101, 1'b0, 1'b0);
        wait_out(0, "bp_latency");
        for (int k = 0; k < 3; k++) begin
            a = 16'($urandom); b = 16'($urandom); in_valid[0] = k[0] == 1'b0;
            @(posedge clk); @(negedge clk);
            check("bp_hold", {r_ovf[0], r_co[0], r_sum[0]}, {2'b00, 16'h1335});
            check("bp_out_valid", 32'(out_valid[0]), 1);
            check("bp_in_ready", 32'(in_ready[0]), 0);
        end
        in_valid[0] = 1'b0; out_ready[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready[0] = 1'b0;
        check("bp_transfer", 32'(out_valid[0]), 0);
        check("bp_in_ready_after", 32'(in_ready[0]), 1);
        check("bp_sum_kept", 32'(r_sum[0]), 32'h1335);
        @(negedge clk);
        check("bp_no_second", 32'(out_valid[0]), 0);

        accept(0, 16'h1234, 16'h1111, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid[0]), 0);
        check("mid_rst_sum", 32'(r_sum[0]), 0);
        check("mid_rst_in_ready", 32'(in_ready[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_in_ready", 32'(in_ready[0]), 1);
        repeat (5) @(negedge clk);
        check("mid_no_result", 32'(out_valid[0]), 0);
        run(0, 16'h0001, 16'h0001, 1'b0, 1'b0, res);
        check("post_rst_op", 32'(res), {2'b00, 16'h0002});

        run(1, 16'h1234, 16'h4321, 1'b1, 1'b0, res);
        check("n1_result", 32'(res), {2'b00, 16'h5556});
        run(2, 16'h1234, 16'h4321, 1'b1, 1'b0, res);
        check("n16_result", 32'(res), {2'b00, 16'h5556});

        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 20; k++)
                run(d, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), res);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
